// File: rtl/jtdd_adpcm_pkg.sv
// Shared constants for the OKI/Dialogic ADPCM sample player.
`timescale 1ns/1ps
package jtdd_adpcm_pkg;

    localparam int unsigned StepCount = 49;
    localparam logic [5:0]  MaxIdx    = 6'd48;
    // cen_oki pulses per decoder sample tick, minus one
    localparam logic [5:0]  PreMax    = 6'd47;

    typedef enum logic [1:0] {
        RegStart = 2'd0,
        RegEnd   = 2'd1,
        RegPos   = 2'd2,
        RegStop  = 2'd3
    } reg_sel_e;

    localparam logic [10:0] StepTable [StepCount] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
        11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
        11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
        11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
        11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
        11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
        11'd1552
    };

    localparam logic signed [4:0] AdjTable [8] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    // Magnitude of the delta for one nibble; the sign bit is applied by the caller.
    function automatic logic [13:0] adpcm_diff(input logic [10:0] step, input logic [2:0] mag);
        logic [13:0] s;
        s = {3'b000, step};
        return (s >> 3)
             + (mag[0] ? (s >> 2) : 14'd0)
             + (mag[1] ? (s >> 1) : 14'd0)
             + (mag[2] ? s : 14'd0);
    endfunction

endpackage

// File: rtl/jtdd_adpcm_dec.sv
// One-nibble ADPCM decoder: holds the running signal and step index.
`timescale 1ns/1ps
module jtdd_adpcm_dec
    import jtdd_adpcm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [3:0]         nibble_i,
    output logic signed [11:0] snd_o
);

    logic signed [11:0] sig_q, sig_d;
    logic [5:0]         idx_q, idx_d;
    logic [13:0]        diff;
    logic signed [13:0] sig_ext, sum;
    logic signed [4:0]  adj;
    logic signed [7:0]  idx_sum;

    // Next signal/index: clear has priority over a decode step.
    always_comb begin
        diff    = adpcm_diff(StepTable[idx_q], nibble_i[2:0]);
        sig_ext = {{2{sig_q[11]}}, sig_q};
        sum     = nibble_i[3] ? (sig_ext - $signed(diff)) : (sig_ext + $signed(diff));
        adj     = AdjTable[nibble_i[2:0]];
        idx_sum = $signed({2'b00, idx_q}) + $signed({{3{adj[4]}}, adj});
        sig_d   = sig_q;
        idx_d   = idx_q;
        if (clr_i) begin
            sig_d = '0;
            idx_d = '0;
        end else if (en_i) begin
            if (sum > 14'sd2047) begin
                sig_d = 12'sh7FF;
            end else if (sum < -14'sd2048) begin
                sig_d = 12'sh800;
            end else begin
                sig_d = sum[11:0];
            end
            if (idx_sum < 8'sd0) begin
                idx_d = '0;
            end else if (idx_sum > 8'sd48) begin
                idx_d = MaxIdx;
            end else begin
                idx_d = idx_sum[5:0];
            end
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
            idx_q <= '0;
        end else begin
            sig_q <= sig_d;
            idx_q <= idx_d;
        end
    end

    assign snd_o = sig_q;

endmodule

// File: rtl/jtdd_adpcm.sv
// CPU-controlled ADPCM sample player: register file, prescaler, ROM fetch, nibble sequencing.
`timescale 1ns/1ps
module jtdd_adpcm
    import jtdd_adpcm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_cen,
    input  logic               cen_oki,
    input  logic [7:0]         cpu_dout,
    input  logic [1:0]         cpu_AB,
    input  logic               cs,
    output logic [15:0]        rom_addr,
    output logic               rom_cs,
    input  logic [7:0]         rom_data,
    input  logic               rom_ok,
    output logic signed [11:0] snd,
    output logic               sample
);

    logic [5:0]  pre_q, pre_d;
    logic        playing_q, playing_d;
    logic        phase_q, phase_d;     // 1 = high nibble next
    logic [16:0] pos_q, pos_d;         // bit 16 flags running off the ROM
    logic [15:0] end_q, end_d;
    logic [7:0]  latch_q, latch_d;
    logic        tick, wr, dec_en, dec_clr;
    logic [3:0]  nibble;
    reg_sel_e    sel;
    logic        unused_dout7;

    assign unused_dout7 = cpu_dout[7];
    assign wr           = cs & cpu_cen;
    assign sel          = reg_sel_e'(cpu_AB);
    assign tick         = cen_oki && (pre_q == PreMax);
    assign nibble       = phase_q ? latch_q[7:4] : latch_q[3:0];

    // Prescaler and ROM byte capture.
    always_comb begin
        pre_d = pre_q;
        if (cen_oki) begin
            pre_d = (pre_q == PreMax) ? 6'd0 : pre_q + 6'd1;
        end
        latch_d = (rom_cs && rom_ok) ? rom_data : latch_q;
    end

    // Playback sequencing on ticks, then CPU writes override the affected registers.
    always_comb begin
        playing_d = playing_q;
        phase_d   = phase_q;
        pos_d     = pos_q;
        end_d     = end_q;
        dec_en    = 1'b0;
        dec_clr   = 1'b0;
        if (tick && playing_q) begin
            if (phase_q) begin
                if (pos_q[16] || (pos_q[15:0] >= end_q)) begin
                    playing_d = 1'b0;
                    dec_clr   = 1'b1;
                end else begin
                    dec_en  = 1'b1;
                    phase_d = 1'b0;
                end
            end else begin
                dec_en  = 1'b1;
                pos_d   = pos_q + 17'd1;
                phase_d = 1'b1;
            end
        end
        if (wr) begin
            unique case (sel)
                RegStart: begin
                    playing_d = 1'b1;
                    phase_d   = 1'b1;
                end
                RegEnd: end_d = {cpu_dout[6:0], 9'd0};
                RegPos: pos_d = {1'b0, cpu_dout[6:0], 9'd0};
                RegStop: begin
                    playing_d = 1'b0;
                    dec_clr   = 1'b1;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q     <= '0;
            playing_q <= 1'b0;
            phase_q   <= 1'b1;
            pos_q     <= '0;
            end_q     <= '0;
            latch_q   <= '0;
        end else begin
            pre_q     <= pre_d;
            playing_q <= playing_d;
            phase_q   <= phase_d;
            pos_q     <= pos_d;
            end_q     <= end_d;
            latch_q   <= latch_d;
        end
    end

    jtdd_adpcm_dec u_dec (
        .clk      (clk),
        .rst      (rst),
        .en_i     (dec_en),
        .clr_i    (dec_clr),
        .nibble_i (nibble),
        .snd_o    (snd)
    );

    assign rom_cs   = playing_q;
    assign rom_addr = pos_q[15:0];
    assign sample   = tick;

endmodule

// File: tb/tb_jtdd_adpcm.sv
// Scoreboard bench for jtdd_adpcm: stimulus queues per-tick expectations, monitor checks them.
`timescale 1ns/1ps
module tb_jtdd_adpcm;

    logic               clk = 1'b0;
    logic               rst, cpu_cen, cen_oki, cs, rom_ok, rom_cs, sample;
    logic [7:0]         cpu_dout, rom_data, rom_fill;
    logic [1:0]         cpu_AB;
    logic [15:0]        rom_addr;
    logic signed [11:0] snd;

    int n_total    = 0;
    int n_bad      = 0;
    int ticks_done = 0;
    int tick_seen  = 0;
    int oki_since  = 0;

    typedef struct {
        int          tick;
        int          snd;
        logic        cs;
        logic [15:0] addr;
    } exp_t;
    exp_t sb_q[$];

    // Hand-computed decoder outputs for repeated nibble 7 / nibble 15 from idx 0
    int pos_vals [8] = '{30, 93, 229, 522, 1153, 2047, 2047, 2047};
    int neg_vals [8] = '{-30, -93, -229, -522, -1153, -2048, -2048, -2048};

    always #5 clk = ~clk;

    jtdd_adpcm dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_cen  (cpu_cen),
        .cen_oki  (cen_oki),
        .cpu_dout (cpu_dout),
        .cpu_AB   (cpu_AB),
        .cs       (cs),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .snd      (snd),
        .sample   (sample)
    );

    task automatic chk(input string name, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic exp_at(input int k, input int s, input logic c, input logic [15:0] a);
        exp_t e;
        e.tick = ticks_done + k;
        e.snd  = s;
        e.cs   = c;
        e.addr = a;
        sb_q.push_back(e);
    endtask

    // Called at edge+2; returns at edge+2 after the write edge.
    task automatic wr(input logic [1:0] ab, input logic [7:0] d, input logic cen);
        cs       = 1'b1;
        cpu_cen  = cen;
        cpu_AB   = ab;
        cpu_dout = d;
        @(posedge clk);
        #1;
        cs      = 1'b0;
        cpu_cen = 1'b0;
        #1;
    endtask

    // Issue n*48 cen_oki pulses, each high for one edge, with gap idle clocks between.
    task automatic run_ticks(input int n, input int gap);
        for (int i = 0; i < n * 48; i++) begin
            cen_oki = 1'b1;
            @(posedge clk);
            #2;
            cen_oki = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #2;
            end
        end
        ticks_done += n;
    endtask

    // ROM: one-clock latency, constant fill byte chosen by the stimulus
    initial begin
        rom_ok   = 1'b0;
        rom_data = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            rom_ok   = rom_cs;
            rom_data = rom_fill;
        end
    end

    // Monitor: on each sample pulse check pulse spacing and pop matching expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cen_oki) oki_since++;
            if (sample) begin
                tick_seen++;
                chk("oki_per_tick", oki_since, 48);
                oki_since = 0;
                @(posedge clk);
                #1;
                chk("sample_width", int'(sample), 0);
                while (sb_q.size() > 0 && sb_q[0].tick == tick_seen) begin
                    e = sb_q.pop_front();
                    chk($sformatf("t%0d_snd", e.tick), int'(snd), e.snd);
                    chk($sformatf("t%0d_rom_cs", e.tick), int'(rom_cs), int'(e.cs));
                    chk($sformatf("t%0d_rom_addr", e.tick), int'(rom_addr), int'(e.addr));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        cpu_cen  = 1'b0;
        cen_oki  = 1'b0;
        cs       = 1'b0;
        cpu_dout = 8'h00;
        cpu_AB   = 2'd0;
        rom_fill = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rom_cs", int'(rom_cs), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_snd", int'(snd), 0);
        chk("rst_sample", int'(sample), 0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Idle: 200 ticks, nothing plays
        for (int k = 1; k <= 200; k++) exp_at(k, 0, 1'b0, 16'h0000);
        run_ticks(200, 1);

        // Play 0x0200..0x0400 of 0x80 bytes: -2 / 0 alternating, then stop at end
        rom_fill = 8'h80;
        wr(2'd2, 8'h05, 1'b0);  // cpu_cen low: ignored
        wr(2'd2, 8'h01, 1'b1);
        wr(2'd1, 8'h02, 1'b1);
        wr(2'd0, 8'h00, 1'b1);
        chk("start_rom_cs", int'(rom_cs), 1);
        chk("start_rom_addr", int'(rom_addr), 16'h0200);
        exp_at(1, -2, 1'b1, 16'h0200);
        exp_at(2, 0, 1'b1, 16'h0201);
        exp_at(3, -2, 1'b1, 16'h0201);
        exp_at(4, 0, 1'b1, 16'h0202);
        exp_at(1023, -2, 1'b1, 16'h03FF);
        exp_at(1024, 0, 1'b1, 16'h0400);
        exp_at(1025, 0, 1'b0, 16'h0400);
        exp_at(1026, 0, 1'b0, 16'h0400);
        run_ticks(1026, 0);

        // Repeated 0x77: rising to +2047 saturation
        rom_fill = 8'h77;
        wr(2'd2, 8'h10, 1'b1);
        wr(2'd1, 8'h7F, 1'b1);
        wr(2'd0, 8'h00, 1'b1);
        for (int k = 1; k <= 8; k++) exp_at(k, pos_vals[k-1], 1'b1, 16'(32'h2000 + k / 2));
        run_ticks(8, 0);

        // Stop mid-playback clears output next clock, position held
        wr(2'd3, 8'h00, 1'b1);
        chk("stop_rom_cs", int'(rom_cs), 0);
        chk("stop_snd", int'(snd), 0);
        chk("stop_rom_addr", int'(rom_addr), 16'h2004);

        // Resume with 0xFF bytes: falling to -2048, idx pinned at 48
        rom_fill = 8'hFF;
        wr(2'd0, 8'h00, 1'b1);
        chk("resume_rom_cs", int'(rom_cs), 1);
        chk("resume_rom_addr", int'(rom_addr), 16'h2004);
        for (int k = 1; k <= 8; k++) exp_at(k, neg_vals[k-1], 1'b1, 16'(32'h2004 + k / 2));
        run_ticks(8, 0);

        // High nibble 0 from idx 48: -2048 + 194
        rom_fill = 8'h08;
        exp_at(1, -1854, 1'b1, 16'h2008);
        run_ticks(1, 0);

        // Restart while playing: phase back to high, signal kept; idx 47 step 1411
        wr(2'd0, 8'h00, 1'b1);
        exp_at(1, -1678, 1'b1, 16'h2008);
        run_ticks(1, 0);

        // end=0 while playing: low nibble 8 (idx 46 step 1282) then stop at high phase
        wr(2'd1, 8'h00, 1'b1);
        exp_at(1, -1838, 1'b1, 16'h2009);
        exp_at(2, 0, 1'b0, 16'h2009);
        run_ticks(2, 0);

        // Start with end=0: first tick stops without decoding
        wr(2'd0, 8'h00, 1'b1);
        chk("end0_rom_cs", int'(rom_cs), 1);
        exp_at(1, 0, 1'b0, 16'h2009);
        run_ticks(1, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", sb_q.size(), 0);
        chk("tick_count", tick_seen, ticks_done);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
